async_up_counter: RTL and testbench



---
 rtl/async_up_counter.sv | 67 ++++++
 tb/tb_async_up_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/async_up_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : async_up_counter                                                |
// | Brief    : WIDTH-stage ripple binary up-counter of toggle flip-flops with  |
// |            asynchronous active-low clear. Defining ASYNC_UP_COUNTER_TC_EN  |
// |            adds the terminal-count output TC.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module async_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             E,
`ifdef ASYNC_UP_COUNTER_TC_EN
    output logic             TC,
`endif
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] w_q;
    logic             r_released;

    // Set by the rising edge of CLR itself. Its new value only appears after
    // that instant, so a CLK edge coinciding with the release still sees 0.
    always_ff @(posedge CLR or negedge CLR) begin
        if (!CLR) begin
            r_released <= 1'b0;
        end else begin
            r_released <= 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic r_bit;

        if (i == 0) begin : g_first
            always_ff @(posedge CLK or negedge CLR) begin
                if (!CLR) begin
                    r_bit <= 1'b0;
                end else if (E && r_released) begin
                    r_bit <= ~r_bit;
                end
            end
        end else begin : g_ripple
            // The clear term wins over the upstream falling edge it produces.
            always_ff @(negedge w_q[i-1] or negedge CLR) begin
                if (!CLR) begin
                    r_bit <= 1'b0;
                end else begin
                    r_bit <= ~r_bit;
                end
            end
        end

        assign w_q[i] = r_bit;
    end

    assign Q = w_q;

`ifdef ASYNC_UP_COUNTER_TC_EN
    assign TC = CLR & E & (&w_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_up_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_async_up_counter                                             |
// | Brief    : Scoreboard bench for async_up_counter; Q (and TC when enabled)  |
// |            is compared on each CLK falling edge with a queued expectation. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_async_up_counter;

    typedef struct {
        int    q;
        bit    tc;
        string name;
    } exp_t;

    logic       CLK;
    logic       CLR;
    logic       E;
    logic [3:0] Q;
    logic       tc_mon;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

`ifdef ASYNC_UP_COUNTER_TC_EN
    localparam bit c_check_tc = 1'b1;
    async_up_counter #(.WIDTH(4)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .E   (E),
        .TC  (tc_mon),
        .Q   (Q)
    );
`else
    localparam bit c_check_tc = 1'b0;
    async_up_counter #(.WIDTH(4)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .E   (E),
        .Q   (Q)
    );
    assign tc_mon = 1'b0;
`endif

    initial CLK = 1'b0;
    always #20 CLK = ~CLK;

    // Monitor: settled outputs are presented on every CLK falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_cmp++;
                if ((Q !== 4'(x.q)) || (c_check_tc && (tc_mon !== x.tc))) begin
                    n_fail++;
                    $display("FAIL %s: got Q=%0d TC=%0b, expected Q=%0d TC=%0b",
                             x.name, Q, tc_mon, x.q, x.tc);
                end
            end
        end
    end

    task automatic push_exp(input int qv, input bit tcv, input string nm);
        exp_t x;
        x.q    = qv;
        x.tc   = tcv;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Called with CLK low; applies E for the next rising edge.
    task automatic tick(input bit e, input int qv, input string nm);
        E = e;
        @(posedge CLK);
        #1;
        push_exp(qv, e && (qv == 15), nm);
        @(negedge CLK);
        #1;
    endtask

    // Hold edge with E pulsing high while CLK is high, away from any rising edge.
    task automatic tick_glitch(input int qv, input string nm);
        E = 1'b0;
        @(posedge CLK);
        #5 E = 1'b1;
        #5 E = 1'b0;
        push_exp(qv, 1'b0, nm);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 50000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLR = 1'b1;
        E   = 1'b1;
        #1 CLR = 1'b0;

        // Release coincides with the rising edge at 20 ns: that edge is ignored.
        @(posedge CLK);
        CLR = 1'b1;
        #1;
        push_exp(0, 1'b0, "coincident_release");
        @(negedge CLK);
        #1;

        for (int i = 1; i <= 16; i++) tick(1'b1, i % 16, "wrap_count");
        for (int i = 1; i <= 5; i++)  tick(1'b1, i, "count_to_5");
        for (int i = 0; i < 4; i++)   tick_glitch(5, "hold_e0");
        for (int i = 6; i <= 9; i++)  tick(1'b1, i, "resume_count");

        // Clear pulse between edges while Q=9.
        E = 1'b0;
        @(posedge CLK);
        #5 CLR = 1'b0;
        push_exp(0, 1'b0, "clear_immediate");
        @(negedge CLK);
        #5 CLR = 1'b1;
        #1;
        tick(1'b1, 1, "after_clear");

        for (int i = 2; i <= 15; i++) tick(1'b1, i, "tc_run");
        tick(1'b0, 15, "tc_hold_e0");

        // Clear at Q=15 with E=1, held across a rising edge.
        E   = 1'b1;
        CLR = 1'b0;
        #1;
        push_exp(0, 1'b0, "clear_at_15");
        @(negedge CLK);
        #5 CLR = 1'b1;
        #1;
        tick(1'b1, 1, "after_clear_15");
        tick(1'b1, 2, "after_clear_15");

        repeat (3) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
